prog_load_ctrl: RTL and testbench

//   Sequences UART program download into the program ROM. Assembles received bytes into 32-bit

---
 rtl/prog_load_ctrl_if.sv | 40 ++++
 rtl/prog_load_ctrl.sv | 266 ++++++++++++++++++++++++++
 tb/tb_prog_load_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/prog_load_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : prog_load_ctrl_if
//  Description : Bundles the signals between the program-load controller and
//                its surroundings: the UART byte stream, the start pulse, the
//                program-ROM upload port and the CPU hold/status outputs.
//                master = host side (drives start / UART bytes, observes
//                         the ROM port and status)
//                slave  = the controller itself
//  Parameters  : ADDR_W - ROM word-address width
//  Revision    : 1.0 - initial release
// ============================================================================
interface prog_load_ctrl_if #(
    parameter int ADDR_W = 14
);
    logic              start;       // 1-cycle pulse: begin / restart a download
    logic              rx_valid;    // UART byte available
    logic [7:0]        rx_data;     // UART byte
    logic              rx_ready;    // controller accepts byte
    logic              upg_wen_o;   // ROM write strobe
    logic [ADDR_W-1:0] upg_adr_o;   // ROM word address
    logic [31:0]       upg_dat_o;   // ROM write data
    logic              upg_done_o;  // 1 = ROM in CPU-fetch mode
    logic              cpu_hold;    // 1 = hold CPU in reset
    logic              busy;        // load in progress
    logic              err;         // load failed (sticky until next start)

    modport master (
        output start, rx_valid, rx_data,
        input  rx_ready, upg_wen_o, upg_adr_o, upg_dat_o,
        input  upg_done_o, cpu_hold, busy, err
    );

    modport slave (
        input  start, rx_valid, rx_data,
        output rx_ready, upg_wen_o, upg_adr_o, upg_dat_o,
        output upg_done_o, cpu_hold, busy, err
    );
endinterface
`default_nettype wire

// File: rtl/prog_load_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : prog_load_ctrl
//  Description : Sequences a UART program download into the program ROM.
//                A 2-byte little-endian header gives the word count N, then
//                4N data bytes follow, packed little-endian into 32-bit words
//                and written to consecutive ROM addresses starting at 0.
//                The CPU is held in reset while a load is in progress or has
//                failed; the ROM returns to CPU-fetch mode on completion.
//  Ports       : clk      - system clock
//                rst      - asynchronous reset, active low
//                bus      - prog_load_ctrl_if.slave (start, UART byte stream,
//                           ROM upload port, cpu_hold / busy / err status)
//  Parameters  : ADDR_W    - ROM word-address width
//                MAX_WORDS - largest accepted word count
//                TIMEOUT   - idle cycles allowed between bytes once started
//  Options     : UPG_CHECKSUM_EN - when defined, one XOR checksum byte over
//                all data bytes follows the last word and is verified.
//  Revision    : 1.0 - initial release
// ============================================================================
module prog_load_ctrl #(
    parameter int ADDR_W    = 14,
    parameter int MAX_WORDS = 16384,
    parameter int TIMEOUT   = 1000000
) (
    input  wire logic        clk,
    input  wire logic        rst,
    prog_load_ctrl_if.slave  bus
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_CHK   = 3'd4,
        S_DONE  = 3'd5,
        S_ERROR = 3'd6
    } state_t;

    // State entered once all words (possibly zero) have been written
`ifdef UPG_CHECKSUM_EN
    localparam state_t c_AFTER_LAST = S_CHK;
`else
    localparam state_t c_AFTER_LAST = S_DONE;
`endif

    // ------------------------------------------------------------------
    // Registers and their next-state values
    // ------------------------------------------------------------------
    state_t            r_state,   w_state_nxt;
    logic [1:0]        r_bcnt,    w_bcnt_nxt;     // byte position in header/word
    logic [7:0]        r_hdr_lo,  w_hdr_lo_nxt;   // first header byte
    logic [15:0]       r_n,       w_n_nxt;        // word count N
    logic [15:0]       r_idx,     w_idx_nxt;      // word index being assembled
    logic [31:0]       r_word,    w_word_nxt;     // word under assembly
    logic [TMO_W-1:0]  r_tmo,     w_tmo_nxt;      // idle-cycle counter
    logic              r_tmo_en,  w_tmo_en_nxt;   // timeout armed
`ifdef UPG_CHECKSUM_EN
    logic [7:0]        r_xor,     w_xor_nxt;      // running XOR of data bytes
`endif

    // Registered outputs
    logic              r_rx_ready;
    logic              r_wen;
    logic [ADDR_W-1:0] r_adr;
    logic [31:0]       r_dat;
    logic              r_done;
    logic              r_hold;
    logic              r_busy;
    logic              r_err;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic        w_xfer;
    logic [15:0] w_hdr;
    logic        w_last;
    logic        w_tmo_hit;
    logic        w_busy_nxt;

    assign w_xfer    = bus.rx_valid & r_rx_ready;
    assign w_hdr     = {bus.rx_data, r_hdr_lo};
    assign w_last    = ((r_idx + 16'd1) == r_n);
    // Error fires on the cycle that would complete TIMEOUT idle cycles
    assign w_tmo_hit = r_tmo_en && !w_xfer && (r_tmo == TMO_W'(TIMEOUT - 1));

    // ------------------------------------------------------------------
    // Next-state / datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_bcnt_nxt   = r_bcnt;
        w_hdr_lo_nxt = r_hdr_lo;
        w_n_nxt      = r_n;
        w_idx_nxt    = r_idx;
        w_word_nxt   = r_word;
        w_tmo_en_nxt = r_tmo_en;
        w_tmo_nxt    = r_tmo;
`ifdef UPG_CHECKSUM_EN
        w_xor_nxt    = r_xor;
`endif

        if (r_tmo_en) begin
            w_tmo_nxt = w_xfer ? '0 : r_tmo + TMO_W'(1);
        end

        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                // Left only through start (handled below) or reset
            end

            S_HDR: begin
                if (w_xfer) begin
                    if (r_bcnt == 2'd0) begin
                        w_hdr_lo_nxt = bus.rx_data;
                        w_bcnt_nxt   = 2'd1;
                        w_tmo_en_nxt = 1'b1;
                        w_tmo_nxt    = '0;
                    end else begin
                        w_bcnt_nxt = 2'd0;
                        w_n_nxt    = w_hdr;
                        if (w_hdr == 16'd0) begin
                            w_state_nxt = c_AFTER_LAST;
                        end else if (32'(w_hdr) > 32'(MAX_WORDS)) begin
                            w_state_nxt = S_ERROR;
                        end else begin
                            w_state_nxt = S_DATA;
                        end
                    end
                end else if (w_tmo_hit) begin
                    w_state_nxt = S_ERROR;
                end
            end

            S_DATA: begin
                if (w_xfer) begin
                    case (r_bcnt)
                        2'd0:    w_word_nxt[7:0]   = bus.rx_data;
                        2'd1:    w_word_nxt[15:8]  = bus.rx_data;
                        2'd2:    w_word_nxt[23:16] = bus.rx_data;
                        default: w_word_nxt[31:24] = bus.rx_data;
                    endcase
`ifdef UPG_CHECKSUM_EN
                    w_xor_nxt  = r_xor ^ bus.rx_data;
`endif
                    w_bcnt_nxt = r_bcnt + 2'd1;
                    if (r_bcnt == 2'd3) begin
                        w_state_nxt = S_WRITE;
                    end
                end else if (w_tmo_hit) begin
                    w_state_nxt = S_ERROR;
                end
            end

            S_WRITE: begin
                w_idx_nxt   = r_idx + 16'd1;
                w_state_nxt = w_last ? c_AFTER_LAST : S_DATA;
            end

            S_CHK: begin
`ifdef UPG_CHECKSUM_EN
                if (w_xfer) begin
                    w_state_nxt = (bus.rx_data == r_xor) ? S_DONE : S_ERROR;
                end else if (w_tmo_hit) begin
                    w_state_nxt = S_ERROR;
                end
`else
                w_state_nxt = S_ERROR;
`endif
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // start wins over everything, including a byte in the same cycle
        if (bus.start) begin
            w_state_nxt  = S_HDR;
            w_bcnt_nxt   = 2'd0;
            w_n_nxt      = 16'd0;
            w_idx_nxt    = 16'd0;
            w_tmo_en_nxt = 1'b0;
            w_tmo_nxt    = '0;
`ifdef UPG_CHECKSUM_EN
            w_xor_nxt    = 8'd0;
`endif
        end

        // Timeout only matters while a load is active
        if (!(w_state_nxt == S_HDR || w_state_nxt == S_DATA ||
              w_state_nxt == S_WRITE || w_state_nxt == S_CHK)) begin
            w_tmo_en_nxt = 1'b0;
            w_tmo_nxt    = '0;
        end
    end

    assign w_busy_nxt = (w_state_nxt == S_HDR)   || (w_state_nxt == S_DATA) ||
                        (w_state_nxt == S_WRITE) || (w_state_nxt == S_CHK);

    // ------------------------------------------------------------------
    // State and output registers. Outputs are decoded from the next state
    // so they line up with the state register cycle by cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_bcnt     <= 2'd0;
            r_hdr_lo   <= 8'd0;
            r_n        <= 16'd0;
            r_idx      <= 16'd0;
            r_word     <= 32'd0;
            r_tmo      <= '0;
            r_tmo_en   <= 1'b0;
`ifdef UPG_CHECKSUM_EN
            r_xor      <= 8'd0;
`endif
            r_rx_ready <= 1'b0;
            r_wen      <= 1'b0;
            r_adr      <= '0;
            r_dat      <= 32'd0;
            r_done     <= 1'b1;
            r_hold     <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_bcnt     <= w_bcnt_nxt;
            r_hdr_lo   <= w_hdr_lo_nxt;
            r_n        <= w_n_nxt;
            r_idx      <= w_idx_nxt;
            r_word     <= w_word_nxt;
            r_tmo      <= w_tmo_nxt;
            r_tmo_en   <= w_tmo_en_nxt;
`ifdef UPG_CHECKSUM_EN
            r_xor      <= w_xor_nxt;
`endif
            r_rx_ready <= (w_state_nxt == S_HDR) || (w_state_nxt == S_DATA) ||
                          (w_state_nxt == S_CHK);
            r_wen      <= (w_state_nxt == S_WRITE);
            r_busy     <= w_busy_nxt;
            r_hold     <= w_busy_nxt || (w_state_nxt == S_ERROR);
            r_done     <= !(w_busy_nxt || (w_state_nxt == S_ERROR));
            r_err      <= (w_state_nxt == S_ERROR);
            // Address/data present the completed word for the WRITE cycle
            if (w_state_nxt == S_WRITE) begin
                r_adr <= r_idx[ADDR_W-1:0];
                r_dat <= w_word_nxt;
            end
        end
    end

    assign bus.rx_ready   = r_rx_ready;
    assign bus.upg_wen_o  = r_wen;
    assign bus.upg_adr_o  = r_adr;
    assign bus.upg_dat_o  = r_dat;
    assign bus.upg_done_o = r_done;
    assign bus.cpu_hold   = r_hold;
    assign bus.busy       = r_busy;
    assign bus.err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_prog_load_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prog_load_ctrl
//  Description : Self-checking bench for prog_load_ctrl. Loads are described
//                as a word count plus a byte list; the expected ROM writes,
//                checksum and final status are derived from that list.
//                Honours UPG_CHECKSUM_EN the same way as the design.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_load_ctrl;

    localparam int ADDR_W    = 14;
    localparam int MAX_WORDS = 8;
    localparam int TIMEOUT   = 40;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    prog_load_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    prog_load_ctrl #(
        .ADDR_W    (ADDR_W),
        .MAX_WORDS (MAX_WORDS),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int                n_tests = 0;
    int                n_fail  = 0;
    int                max_gap = 0;
    logic [7:0]        data_q[$];
    logic [ADDR_W-1:0] mon_adr[$];
    logic [31:0]       mon_dat[$];

    // Record every ROM write strobe
    always @(negedge clk) begin
        if (bus.upg_wen_o === 1'b1) begin
            mon_adr.push_back(bus.upg_adr_o);
            mon_dat.push_back(bus.upg_dat_o);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_status(input string tag, input logic done, input logic hold,
                                input logic busy, input logic err, input logic ready);
        check({tag, ".upg_done"}, 32'(bus.upg_done_o), 32'(done));
        check({tag, ".cpu_hold"}, 32'(bus.cpu_hold),   32'(hold));
        check({tag, ".busy"},     32'(bus.busy),       32'(busy));
        check({tag, ".err"},      32'(bus.err),        32'(err));
        check({tag, ".rx_ready"}, 32'(bus.rx_ready),   32'(ready));
    endtask

    // All drivers below are called at a falling edge and return at one.
    task automatic do_start(input logic with_byte, input logic [7:0] b);
        bus.start    = 1'b1;
        bus.rx_valid = with_byte;
        bus.rx_data  = b;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int gap;
        int w;
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        w   = 0;
        repeat (gap) @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        while (bus.rx_ready !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (w >= 100) check("rx_ready_wait", 32'(bus.rx_ready), 32'd1);
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    // Full download of n words. fill=1 draws fresh random data, otherwise
    // data_q already holds 4n bytes. drop=1 presents a stray byte together
    // with start, which must be ignored.
    task automatic load(input int n, input bit chk_ok, input bit fill, input bit drop);
        logic [7:0] x;
        bit         exp_ok;
        mon_adr.delete();
        mon_dat.delete();
        if (fill) begin
            data_q.delete();
            if (n <= MAX_WORDS)
                for (int i = 0; i < 4 * n; i++) data_q.push_back(8'($urandom));
        end
        do_start(drop, 8'hAA);
        send_byte(n[7:0]);
        send_byte(n[15:8]);
        if (n > MAX_WORDS) begin
            repeat (2) @(negedge clk);
            check_status("hdr_big", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
            check("hdr_big.writes", mon_adr.size(), 0);
            return;
        end
        for (int i = 0; i < 4 * n; i++) send_byte(data_q[i]);
        exp_ok = 1'b1;
`ifdef UPG_CHECKSUM_EN
        x = 8'd0;
        for (int i = 0; i < 4 * n; i++) x = x ^ data_q[i];
        send_byte(chk_ok ? x : (x ^ 8'h01));
        exp_ok = chk_ok;
`endif
        repeat (3) @(negedge clk);
        check("load.nwrites", mon_adr.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < mon_adr.size()) begin
                check("load.adr", 32'(mon_adr[i]), 32'(i));
                check("load.dat", mon_dat[i],
                      {data_q[4*i+3], data_q[4*i+2], data_q[4*i+1], data_q[4*i]});
            end
        end
        if (exp_ok) check_status("load.end_ok",  1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        else        check_status("load.end_bad", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'd0;
        rst          = 1'b0;

        // Reset state and idle behaviour
        repeat (3) @(negedge clk);
        check_status("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset.wen", 32'(bus.upg_wen_o), 32'd0);
        check("reset.adr", 32'(bus.upg_adr_o), 32'd0);
        check("reset.dat", bus.upg_dat_o, 32'd0);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        check_status("idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("idle.writes", mon_adr.size(), 0);

        // Two-word directed download
        data_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        load(2, 1'b1, 1'b0, 1'b0);
        if (mon_dat.size() == 2) begin
            check("dir.word0", mon_dat[0], 32'h0000_0013);
            check("dir.word1", mon_dat[1], 32'h0010_0093);
        end
`ifdef UPG_CHECKSUM_EN
        load(2, 1'b0, 1'b0, 1'b0);
`endif

        // Oversized header, then restart from ERROR
        load(65535, 1'b1, 1'b1, 1'b0);
        do_start(1'b0, 8'h00);
        check_status("restart", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        // No timeout before the first header byte
        repeat (2 * TIMEOUT) @(negedge clk);
        check_status("hdr_wait", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);

        // Word-count boundaries
        load(MAX_WORDS + 1, 1'b1, 1'b1, 1'b0);
        load(MAX_WORDS,     1'b1, 1'b1, 1'b0);
        load(0,             1'b1, 1'b1, 1'b0);

        // Inter-byte timeout
        mon_adr.delete();
        mon_dat.delete();
        do_start(1'b0, 8'h00);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h5A);
        send_byte(8'hA5);
        repeat (TIMEOUT - 1) @(negedge clk);
        check("tmo.before", 32'(bus.err), 32'd0);
        @(negedge clk);
        check_status("tmo.after", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        check("tmo.writes", mon_adr.size(), 0);

        // Restart mid-DATA after three words; stray byte with start dropped
        mon_adr.delete();
        mon_dat.delete();
        do_start(1'b0, 8'h00);
        send_byte(8'h05);
        send_byte(8'h00);
        for (int i = 0; i < 14; i++) send_byte(8'(i + 1));
        repeat (2) @(negedge clk);
        check("mid.writes", mon_adr.size(), 3);
        load(1, 1'b1, 1'b1, 1'b1);

        // Reset in the middle of a load
        do_start(1'b0, 8'h00);
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h77);
        rst = 1'b0;
        #1;
        check_status("midreset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Randomized downloads
        max_gap = 3;
        repeat (25) begin
            int  n;
            bit  ok;
            bit  drop;
            n    = int'($urandom_range(MAX_WORDS, 0));
            if ($urandom_range(7, 0) == 0) n = int'($urandom_range(65535, MAX_WORDS + 1));
            ok   = ($urandom_range(3, 0) != 0);
            drop = 1'($urandom_range(1, 0));
            load(n, ok, 1'b1, drop);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
